// File: rtl/fmcw_pkg.sv
// rtl/fmcw_pkg.sv - shared constants, FSM states and sizing helper for the USB frame packer
package fmcw_pkg;

  localparam int USB_DATA_WIDTH = 8;
  localparam logic [USB_DATA_WIDTH-1:0] START_FLAG_DEFAULT = 8'h5A;
  localparam logic [USB_DATA_WIDTH-1:0] STOP_FLAG_DEFAULT  = 8'hA5;

  typedef enum logic [2:0] {IDLE, HDR, SEQ, PAYLOAD, STOP} state_t;

  function automatic int bytes_per_sample(input int width);
    return (width + USB_DATA_WIDTH - 1) / USB_DATA_WIDTH;
  endfunction

endpackage

// File: rtl/sample_serializer.sv
// rtl/sample_serializer.sv - packs the enabled channels of one sample set and shifts them out MSB byte first
module sample_serializer
  import fmcw_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 12,
  parameter int CHANNELS     = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load,
  input  logic [CHANNELS-1:0]              mask,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] data,
  input  logic                             byte_ready,
  output logic                             byte_valid,
  output logic                             byte_last,
  output logic [USB_DATA_WIDTH-1:0]        byte_data
);

  localparam int BPS = bytes_per_sample(SAMPLE_WIDTH);
  localparam int NB  = CHANNELS * BPS;
  localparam int BW  = NB * USB_DATA_WIDTH;
  localparam int SW  = BPS * USB_DATA_WIDTH;
  localparam int IW  = $clog2(NB + 1);

  logic [BW-1:0] buf_q;
  logic [BW-1:0] pack;
  logic [BW-1:0] lane;
  logic [IW-1:0] cnt_q;
  logic [IW-1:0] pack_cnt;

  // Walking channels high to low leaves the lowest enabled channel in the top bytes.
  always_comb begin
    pack     = '0;
    pack_cnt = '0;
    lane     = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (mask[k]) begin
        lane                    = '0;
        lane[SAMPLE_WIDTH-1:0]  = data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        pack                    = (pack >> SW) | (lane << (BW - SW));
        pack_cnt                = pack_cnt + IW'(BPS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      buf_q <= pack;
      cnt_q <= pack_cnt;
    end else if (byte_ready && byte_valid) begin
      buf_q <= buf_q << USB_DATA_WIDTH;
      cnt_q <= cnt_q - IW'(1);
    end
  end

  assign byte_valid = (cnt_q != '0);
  assign byte_last  = (cnt_q == IW'(1));
  assign byte_data  = buf_q[BW-1 -: USB_DATA_WIDTH];

endmodule

// File: rtl/usb_frame_packer.sv
// rtl/usb_frame_packer.sv - frames sample sets as START, seq, payload, STOP onto a byte valid/ready stream
module usb_frame_packer
  import fmcw_pkg::*;
#(
  parameter int                        SAMPLE_WIDTH = 12,
  parameter int                        CHANNELS     = 2,
  parameter int                        FRAME_LEN    = 1024,
  parameter logic [USB_DATA_WIDTH-1:0] START_FLAG   = START_FLAG_DEFAULT,
  parameter logic [USB_DATA_WIDTH-1:0] STOP_FLAG    = STOP_FLAG_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [CHANNELS-1:0]              chan_en,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] s_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [USB_DATA_WIDTH-1:0]        m_data,
  output logic                             busy,
  output logic                             frame_done,
  output logic [7:0]                       frame_seq
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  state_t                    state, state_n;
  logic [CHANNELS-1:0]       en_q;
  logic [CW-1:0]             sets_q;
  logic [7:0]                seq_q;
  logic                      sets_left;
  logic                      ser_load, ser_ready, ser_valid, ser_last;
  logic [USB_DATA_WIDTH-1:0] ser_data;

  assign sets_left = (sets_q != CW'(FRAME_LEN));
  assign ser_ready = (state == PAYLOAD) && m_ready;
  assign busy      = (state != IDLE);
  assign frame_seq = seq_q;

  always_comb begin
    state_n    = state;
    m_valid    = 1'b0;
    m_data     = '0;
    s_ready    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (start) state_n = HDR;
      HDR: begin
        m_valid = 1'b1;
        m_data  = START_FLAG;
        if (m_ready) state_n = SEQ;
      end
      SEQ: begin
        m_valid = 1'b1;
        m_data  = seq_q;
        // First set is fetched while the sequence byte leaves, keeping the stream gap-free.
        s_ready = m_ready && (en_q != '0);
        if (m_ready) state_n = (en_q == '0) ? STOP : PAYLOAD;
      end
      PAYLOAD: begin
        m_valid = ser_valid;
        m_data  = ser_data;
        s_ready = sets_left && (!ser_valid || (ser_last && m_ready));
        if (!sets_left && ser_last && m_ready) state_n = STOP;
      end
      STOP: begin
        m_valid = 1'b1;
        m_data  = STOP_FLAG;
        if (m_ready) begin
          frame_done = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ser_load = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      en_q   <= '0;
      sets_q <= '0;
      seq_q  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        sets_q <= '0;
        if (start) en_q <= chan_en;
      end else if (ser_load) begin
        sets_q <= sets_q + CW'(1);
      end
      if (frame_done) seq_q <= seq_q + 8'd1;
    end
  end

  sample_serializer #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .CHANNELS    (CHANNELS)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .mask      (en_q),
    .data      (s_data),
    .byte_ready(ser_ready),
    .byte_valid(ser_valid),
    .byte_last (ser_last),
    .byte_data (ser_data)
  );

endmodule

// File: tb/tb_usb_frame_packer.sv
// tb/tb_usb_frame_packer.sv - self-checking bench for usb_frame_packer
module tb_usb_frame_packer;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
  logic [1:0]  chan_en = 2'b00;
  logic [23:0] s_data = '0;
  logic        s_ready, m_valid, busy, frame_done;
  logic [7:0]  m_data, frame_seq;

  logic        bc_start = 1'b0, bc_m_ready = 1'b1, b_s_valid = 1'b0, c_s_valid = 1'b0;
  logic [0:0]  bc_en = 1'b1;
  logic [15:0] b_s_data = '0;
  logic [7:0]  c_s_data = '0;
  logic        b_s_ready, b_m_valid, b_busy, b_done, c_s_ready, c_m_valid, c_busy, c_done;
  logic [7:0]  b_m_data, b_seq, c_m_data, c_seq;

  int          n_cmp = 0, n_bad = 0;
  bq_t         exp_q, cap_q;
  bit          exp_last_q[$];
  logic [7:0]  model_seq = 8'd0;
  logic [11:0] smem[5][2];
  bit          hold_v = 1'b0;
  logic [7:0]  hold_d = 8'd0;

  always #5 clk = ~clk;

  usb_frame_packer #(.SAMPLE_WIDTH(12), .CHANNELS(2), .FRAME_LEN(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chan_en(chan_en), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .busy(busy), .frame_done(frame_done), .frame_seq(frame_seq));

  usb_frame_packer #(.SAMPLE_WIDTH(16), .CHANNELS(1), .FRAME_LEN(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(bc_start), .chan_en(bc_en), .s_valid(b_s_valid),
    .s_ready(b_s_ready), .s_data(b_s_data), .m_valid(b_m_valid), .m_ready(bc_m_ready),
    .m_data(b_m_data), .busy(b_busy), .frame_done(b_done), .frame_seq(b_seq));

  usb_frame_packer #(.SAMPLE_WIDTH(8), .CHANNELS(1), .FRAME_LEN(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(bc_start), .chan_en(bc_en), .s_valid(c_s_valid),
    .s_ready(c_s_ready), .s_data(c_s_data), .m_valid(c_m_valid), .m_ready(bc_m_ready),
    .m_data(c_m_data), .busy(c_busy), .frame_done(c_done), .frame_seq(c_seq));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic chk_q(input string name, input bq_t got, input bq_t req);
    chk({name, "_len"}, got.size(), req.size());
    for (int i = 0; i < got.size() && i < req.size(); i++) chk(name, got[i], req[i]);
  endtask

  // Output checker: every handshaken byte is popped from the expected stream.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hold_d);
      end
      if (!busy) chk("idle_s_ready", s_ready, 0);
      if (m_valid && m_ready) begin
        cap_q.push_back(m_data);
        if (exp_q.size() == 0) fail_now("extra_byte");
        else begin
          chk("byte", m_data, exp_q.pop_front());
          chk("frame_done_at_stop", frame_done, exp_last_q.pop_front());
        end
      end else begin
        chk("frame_done_idle", frame_done, 0);
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
    end
  end

  task automatic run_frame(input logic [1:0] mask, input int nsets, input bit toggle,
                           input bit gaps, input int poke, input int abort_at,
                           output int cyc, output int vcnt);
    int  idx;
    bit  done, acc;
    logic [15:0] w;
    exp_q.push_back(8'h5A); exp_last_q.push_back(1'b0);
    exp_q.push_back(model_seq); exp_last_q.push_back(1'b0);
    if (mask != 2'b00)
      for (int i = 0; i < nsets; i++)
        for (int k = 0; k < 2; k++)
          if (mask[k]) begin
            w = 16'(smem[i][k]);
            exp_q.push_back(w[15:8]); exp_last_q.push_back(1'b0);
            exp_q.push_back(w[7:0]);  exp_last_q.push_back(1'b0);
          end
    exp_q.push_back(8'hA5); exp_last_q.push_back(1'b1);
    model_seq = model_seq + 8'd1;

    @(posedge clk); #1;
    start = 1'b1; chan_en = mask;
    @(posedge clk); #1;
    cyc = 0; vcnt = 0; idx = 0; done = 1'b0;
    while (!done && cyc < 3000) begin
      if (cyc == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_seq", frame_seq, 0);
        chk("rst_s_ready", s_ready, 0);
        exp_q.delete(); exp_last_q.delete(); model_seq = 8'd0;
        s_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      start   = (cyc == poke);
      chan_en = (poke >= 0 && cyc >= poke) ? ~mask : mask;
      s_valid = (mask != 2'b00) && (idx < nsets) && (!gaps || $urandom_range(0, 2) != 0);
      s_data  = {smem[idx][1], smem[idx][0]};
      m_ready = toggle ? cyc[0] : 1'b1;
      @(negedge clk);
      acc = s_valid && s_ready;
      if (m_valid) vcnt++;
      if (frame_done) done = 1'b1;
      cyc++;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    s_valid = 1'b0; start = 1'b0; m_ready = 1'b1;
    if (!done) fail_now("frame_timeout");
    chk("exp_drained", exp_q.size(), 0);
  endtask

  task automatic run_bc();
    int  ib = 0, ic = 0;
    bit  ab, ac;
    bq_t qb, qc, eb, ec;
    logic [15:0] bs[2] = '{16'hBEEF, 16'h1234};
    logic [7:0]  cs[2] = '{8'hC3, 8'h7E};
    @(posedge clk); #1 bc_start = 1'b1;
    @(posedge clk); #1 bc_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      b_s_valid = (ib < 2); b_s_data = bs[ib % 2];
      c_s_valid = (ic < 2); c_s_data = cs[ic % 2];
      @(negedge clk);
      if (b_m_valid) qb.push_back(b_m_data);
      if (c_m_valid) qc.push_back(c_m_data);
      ab = b_s_valid && b_s_ready;
      ac = c_s_valid && c_s_ready;
      @(posedge clk); #1;
      if (ab) ib++;
      if (ac) ic++;
    end
    b_s_valid = 1'b0; c_s_valid = 1'b0;
    eb = '{8'h5A, 8'h00, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'hA5};
    ec = '{8'h5A, 8'h00, 8'hC3, 8'h7E, 8'hA5};
    chk_q("w16_stream", qb, eb);
    chk_q("w8_stream", qc, ec);
    chk("w16_seq", b_seq, 1);
    chk("w8_seq", c_seq, 1);
  endtask

  initial begin
    int  cyc, vcnt;
    bq_t lit;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc, vcnt;
    bq_t lit;
    smem[0][0] = 12'hABC; smem[0][1] = 12'h123;
    smem[1][0] = 12'hFFF; smem[1][1] = 12'h000;
    for (int i = 2; i < 5; i++) begin smem[i][0] = 12'h0; smem[i][1] = 12'h0; end
    #1;
    chk("reset_s_ready", s_ready, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_frame_seq", frame_seq, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_bc();

    // s_valid offered while idle must not be taken
    s_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 s_valid = 1'b0;

    cap_q.delete();
    run_frame(2'b11, 2, 1'b0, 1'b0, -1, -1, cyc, vcnt);
    lit = '{8'h5A, 8'h00, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'hA5};
    chk_q("case1_stream", cap_q, lit);
    chk("case1_cycles", cyc, 11);
    chk("case1_valid_cycles", vcnt, 11);
    chk("case1_frame_seq", frame_seq, 1);

    cap_q.delete();
    run_frame(2'b10, 2, 1'b0, 1'b0, -1, -1, cyc, vcnt);
    lit = '{8'h5A, 8'h01, 8'h01, 8'h23, 8'h00, 8'h00, 8'hA5};
    chk_q("case2_stream", cap_q, lit);

    cap_q.delete();
    run_frame(2'b11, 2, 1'b1, 1'b1, -1, -1, cyc, vcnt);
    lit = '{8'h5A, 8'h02, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'hA5};
    chk_q("case3_stream", cap_q, lit);

    smem[0][0] = 12'h5A5; smem[0][1] = 12'h0F0;
    smem[1][0] = 12'h800; smem[1][1] = 12'h7FF;
    cap_q.delete();
    run_frame(2'b11, 2, 1'b0, 1'b0, 4, -1, cyc, vcnt);
    lit = '{8'h5A, 8'h03, 8'h05, 8'hA5, 8'h00, 8'hF0, 8'h08, 8'h00, 8'h07, 8'hFF, 8'hA5};
    chk_q("case6_stream", cap_q, lit);

    run_frame(2'b11, 2, 1'b0, 1'b0, -1, 5, cyc, vcnt);
    cap_q.delete();
    run_frame(2'b01, 2, 1'b0, 1'b0, -1, -1, cyc, vcnt);
    chk("after_reset_hdr", cap_q[0], 8'h5A);
    chk("after_reset_seq", cap_q[1], 8'h00);

    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_seq = 8'd0;
    for (int f = 0; f < 256; f++) begin
      cap_q.delete();
      run_frame(2'b00, 0, 1'b0, 1'b0, -1, -1, cyc, vcnt);
      chk("case4_seq_byte", cap_q[1], f[7:0]);
      chk("case4_len", cap_q.size(), 3);
    end
    chk("case4_wrapped_seq", frame_seq, 0);
    cap_q.delete();
    run_frame(2'b00, 0, 1'b0, 1'b0, -1, -1, cyc, vcnt);
    chk("case4_next_seq", cap_q[1], 8'h00);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
